// File: rtl/pong_game_graph.sv
// pong_game_graph: Pong pixel generator and game engine. Draws the wall or left
// paddle, the right paddle and a round ball from the current pixel coordinate,
// and runs the serve/play/point/over state machine once per video frame.
module pong_game_graph #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int TWO_PLAYER   = 0,
  parameter int BAR_Y_SIZE   = 72,
  parameter int BAR_V        = 4,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_V       = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  input  logic [3:0]         btn,
  input  logic               start,
  output logic [2:0]         graph_rgb,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over
);

  typedef enum logic [2:0] {S_IDLE, S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [10:0] WALL_X_L  = 11'd32;
  localparam logic [10:0] WALL_X_R  = 11'd35;
  localparam logic [10:0] BAR_X_L   = 11'(H_ACTIVE - 40);
  localparam logic [10:0] BAR_X_R   = 11'(H_ACTIVE - 37);
  localparam logic [10:0] BAR_H_M1  = 11'(BAR_Y_SIZE - 1);
  localparam logic [10:0] BALL_M1   = 11'(BALL_SIZE - 1);
  localparam logic [9:0]  BAR_Y_RST = 10'((V_ACTIVE - BAR_Y_SIZE) / 2);
  localparam logic [9:0]  BALL_X_C  = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]  BALL_Y_C  = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic signed [9:0] V_POS = 10'(BALL_V);
  localparam logic signed [9:0] V_NEG = -V_POS;

  // One paddle step: down wins over up, and a blocked move holds.
  function automatic logic [9:0] bar_step(input logic [9:0] top, input logic dn, input logic up);
    logic [10:0] bot;
    bot      = {1'b0, top} + BAR_H_M1;
    bar_step = top;
    if (dn) begin
      if (bot + 11'(BAR_V) <= 11'(V_ACTIVE - 1)) bar_step = top + 10'(BAR_V);
    end else if (up) begin
      if (top >= 10'(BAR_V)) bar_step = top - 10'(BAR_V);
    end
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    sat_inc = (v == {SCORE_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] ball_rom(input logic [2:0] row);
    case (row)
      3'd0, 3'd7: ball_rom = 8'h3C;
      3'd1, 3'd6: ball_rom = 8'h7E;
      default:    ball_rom = 8'hFF;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic [9:0]              bar_r_q, bar_r_d, bar_l_q, bar_l_d;
  logic [9:0]              ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic signed [9:0]       dx_q, dx_d, dy_q, dy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SCORE_W-1:0]      score_l_q, score_l_d, score_r_q, score_r_d;
  logic                    scorer_l_q, scorer_l_d;
  logic [2:0]              rgb_q, rgb_d;

  logic                    refr_tick;
  logic [10:0]             ball_x_l, ball_x_r, ball_y_t, ball_y_b;
  logic [10:0]             bar_r_t, bar_r_b, bar_l_t, bar_l_b;
  logic                    over_r, over_l, hit_r, hit_l, miss_r, miss_l;
  logic                    launch, game_end;
  logic signed [9:0]       serve_dx;
  logic [10:0]             px, py;
  logic                    wall_on, bar_on, sq_on, ball_vis;
  logic [2:0]              rom_row, rom_col;
  logic [7:0]              rom_bits;

  assign refr_tick = (pix_y == 10'(V_ACTIVE + 1)) && (pix_x == 10'd0);
  assign ball_x_l  = {1'b0, ball_x_q};
  assign ball_x_r  = ball_x_l + BALL_M1;
  assign ball_y_t  = {1'b0, ball_y_q};
  assign ball_y_b  = ball_y_t + BALL_M1;
  assign bar_r_t   = {1'b0, bar_r_q};
  assign bar_r_b   = bar_r_t + BAR_H_M1;
  assign bar_l_t   = {1'b0, bar_l_q};
  assign bar_l_b   = bar_l_t + BAR_H_M1;
  assign over_r    = (ball_y_t <= bar_r_b) && (ball_y_b >= bar_r_t);
  assign over_l    = (ball_y_t <= bar_l_b) && (ball_y_b >= bar_l_t);
  assign hit_r     = (ball_x_r >= BAR_X_L) && (ball_x_r <= BAR_X_R) && over_r;
  assign hit_l     = (ball_x_l >= WALL_X_L) && (ball_x_l <= WALL_X_R) && ((TWO_PLAYER == 0) || over_l);
  assign miss_r    = ball_x_r > (BAR_X_R + 11'(BALL_V));
  assign miss_l    = (TWO_PLAYER != 0) && ((ball_x_l < WALL_X_L) || (ball_x_l >= 11'(H_ACTIVE)));

  // Game state machine, paddle motion and ball physics, all gated by the frame tick.
  always_comb begin
    state_d    = state_q;
    bar_r_d    = bar_r_q;
    bar_l_d    = bar_l_q;
    ball_x_d   = ball_x_q;
    ball_y_d   = ball_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    cnt_d      = cnt_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    scorer_l_d = scorer_l_q;
    launch     = 1'b0;
    game_end   = 1'b0;
    serve_dx   = V_POS;
    if (refr_tick) begin
      bar_r_d = bar_step(bar_r_q, btn[1], btn[0]);
      if (TWO_PLAYER != 0) bar_l_d = bar_step(bar_l_q, btn[3], btn[2]);
    end
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d   = S_SERVE;
          score_l_d = '0;
          score_r_d = '0;
          launch    = 1'b1;
        end
      end
      S_SERVE: begin
        if (refr_tick) begin
          if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
            state_d = S_PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (refr_tick) begin
          if (miss_r) begin
            state_d    = S_POINT;
            scorer_l_d = 1'b1;
          end else if (miss_l) begin
            state_d    = S_POINT;
            scorer_l_d = 1'b0;
          end else begin
            if (ball_y_t <= 11'(BALL_V)) dy_d = V_POS;
            if (ball_y_b >= 11'(V_ACTIVE - 1 - BALL_V)) dy_d = V_NEG;
            if (hit_r) begin
              dx_d = V_NEG;
              if (TWO_PLAYER == 0) score_r_d = sat_inc(score_r_q);
            end
            if (hit_l) dx_d = V_POS;
            ball_x_d = ball_x_q + $unsigned(dx_d);
            ball_y_d = ball_y_q + $unsigned(dy_d);
          end
        end
      end
      S_POINT: begin
        if (refr_tick) begin
          if (scorer_l_q) begin
            score_l_d = score_l_q + 1'b1;
            game_end  = (score_l_d == SCORE_W'(WIN_SCORE));
            serve_dx  = V_POS;
          end else begin
            score_r_d = score_r_q + 1'b1;
            game_end  = (score_r_d == SCORE_W'(WIN_SCORE));
            serve_dx  = V_NEG;
          end
          if (game_end) begin
            state_d = S_OVER;
          end else begin
            state_d = S_SERVE;
            launch  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      ball_x_d = BALL_X_C;
      ball_y_d = BALL_Y_C;
      dx_d     = serve_dx;
      dy_d     = V_POS;
      cnt_d    = '0;
    end
  end

  // Object hit-testing and colour priority for the current pixel.
  always_comb begin
    px       = {1'b0, pix_x};
    py       = {1'b0, pix_y};
    wall_on  = (px >= WALL_X_L) && (px <= WALL_X_R) &&
               ((TWO_PLAYER == 0) || ((py >= bar_l_t) && (py <= bar_l_b)));
    bar_on   = (px >= BAR_X_L) && (px <= BAR_X_R) && (py >= bar_r_t) && (py <= bar_r_b);
    sq_on    = (px >= ball_x_l) && (px <= ball_x_r) && (py >= ball_y_t) && (py <= ball_y_b);
    ball_vis = (state_q != S_IDLE) && (state_q != S_OVER);
    rom_row  = pix_y[2:0] - ball_y_q[2:0];
    rom_col  = pix_x[2:0] - ball_x_q[2:0];
    rom_bits = ball_rom(rom_row);
    rgb_d    = 3'b110;
    if (!video_on)                             rgb_d = 3'b000;
    else if (wall_on)                          rgb_d = 3'b001;
    else if (bar_on)                           rgb_d = 3'b010;
    else if (sq_on && ball_vis && rom_bits[rom_col]) rgb_d = 3'b100;
  end

  // State registers; reset wins over a coincident frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bar_r_q    <= BAR_Y_RST;
      bar_l_q    <= BAR_Y_RST;
      ball_x_q   <= BALL_X_C;
      ball_y_q   <= BALL_Y_C;
      dx_q       <= V_POS;
      dy_q       <= V_POS;
      cnt_q      <= '0;
      score_l_q  <= '0;
      score_r_q  <= '0;
      scorer_l_q <= 1'b0;
      rgb_q      <= 3'b000;
    end else begin
      state_q    <= state_d;
      bar_r_q    <= bar_r_d;
      bar_l_q    <= bar_l_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      cnt_q      <= cnt_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      scorer_l_q <= scorer_l_d;
      rgb_q      <= rgb_d;
    end
  end

  assign graph_rgb = rgb_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_pong_game_graph.sv
// tb_pong_game_graph: drives a one-player and a two-player instance with the
// same pixel/button stream and checks every probed pixel and score against a
// frame-level game model through a FIFO scoreboard.
`timescale 1ns/1ps
module tb_pong_game_graph;
  localparam int H = 640, V = 480, BAR_H = 72, BAR_STEP = 4, BV = 2;
  localparam int SERVE_N = 60, WIN = 2;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_POINT = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       video_on = 1'b0;
  logic [9:0] pix_x = 10'd5, pix_y = 10'd5;
  logic [3:0] btn = 4'd0;
  logic       start = 1'b0;
  logic [2:0] rgb0, rgb1;
  logic [3:0] sl0, sr0, sl1, sr1;
  logic       go0, go1;

  pong_game_graph #(.TWO_PLAYER(0), .WIN_SCORE(WIN)) u_dut1p (
    .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .btn(btn), .start(start), .graph_rgb(rgb0), .score_l(sl0), .score_r(sr0), .game_over(go0));
  pong_game_graph #(.TWO_PLAYER(1), .WIN_SCORE(WIN)) u_dut2p (
    .clk(clk), .reset(reset), .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
    .btn(btn), .start(start), .graph_rgb(rgb1), .score_l(sl1), .score_r(sr1), .game_over(go1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rgb0, rgb1;
    logic [3:0] sl0, sr0, sl1, sr1;
    logic       go0, go1;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0;
  logic probe_active = 1'b0, pend = 1'b0;

  // Game model, index 0 = one player, index 1 = two players.
  int m_st[2], m_bx[2], m_by[2], m_vx[2], m_vy[2], m_pr[2], m_pl[2];
  int m_sl[2], m_sr[2], m_cnt[2];
  bit m_lscored[2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = M_IDLE; m_bx[i] = H/2 - 4; m_by[i] = V/2 - 4; m_vx[i] = BV; m_vy[i] = BV;
      m_pr[i] = (V - BAR_H) / 2; m_pl[i] = (V - BAR_H) / 2;
      m_sl[i] = 0; m_sr[i] = 0; m_cnt[i] = 0; m_lscored[i] = 0;
    end
  endtask

  task automatic center_ball(input int i, input int vx);
    m_bx[i] = H/2 - 4; m_by[i] = V/2 - 4; m_vx[i] = vx; m_vy[i] = BV; m_cnt[i] = 0;
  endtask

  task automatic model_start();
    for (int i = 0; i < 2; i++)
      if (m_st[i] == M_IDLE || m_st[i] == M_OVER) begin
        m_st[i] = M_SERVE; m_sl[i] = 0; m_sr[i] = 0; center_ball(i, BV);
      end
  endtask

  function automatic bit overlaps(int by, int top);
    return (by <= top + BAR_H - 1) && (by + 7 >= top);
  endfunction

  function automatic int paddle_next(int top, bit dn, bit up);
    if (dn) return (top + BAR_H - 1 + BAR_STEP <= V - 1) ? top + BAR_STEP : top;
    if (up) return (top >= BAR_STEP) ? top - BAR_STEP : top;
    return top;
  endfunction

  task automatic model_tick(input int i);
    bit two;
    int rt;
    two = (i == 1);
    rt  = m_bx[i] + 7;
    case (m_st[i])
      M_SERVE: begin
        m_cnt[i]++;
        if (m_cnt[i] == SERVE_N) begin m_st[i] = M_PLAY; m_cnt[i] = 0; end
      end
      M_PLAY: begin
        if (rt > 603 + BV) begin
          m_st[i] = M_POINT; m_lscored[i] = 1;
        end else if (two && (m_bx[i] < 32 || m_bx[i] >= H)) begin
          m_st[i] = M_POINT; m_lscored[i] = 0;
        end else begin
          if (m_by[i] <= BV) m_vy[i] = BV;
          if (m_by[i] + 7 >= V - 1 - BV) m_vy[i] = -BV;
          if (rt >= 600 && rt <= 603 && overlaps(m_by[i], m_pr[i])) begin
            m_vx[i] = -BV;
            if (!two && m_sr[i] < 15) m_sr[i]++;
          end
          if (m_bx[i] >= 32 && m_bx[i] <= 35 && (!two || overlaps(m_by[i], m_pl[i]))) m_vx[i] = BV;
          m_bx[i] = (m_bx[i] + m_vx[i]) & 1023;
          m_by[i] = (m_by[i] + m_vy[i]) & 1023;
        end
      end
      M_POINT: begin
        if (m_lscored[i]) m_sl[i]++; else m_sr[i]++;
        if ((m_lscored[i] ? m_sl[i] : m_sr[i]) == WIN) m_st[i] = M_OVER;
        else begin m_st[i] = M_SERVE; center_ball(i, m_lscored[i] ? BV : -BV); end
      end
      default: ;
    endcase
    m_pr[i] = paddle_next(m_pr[i], btn[1], btn[0]);
    if (two) m_pl[i] = paddle_next(m_pl[i], btn[3], btn[2]);
  endtask

  function automatic logic [7:0] rom_row(int r);
    case (r)
      0, 7:    return 8'h3C;
      1, 6:    return 8'h7E;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [2:0] model_pixel(int i, int x, int y, bit von);
    logic [7:0] row;
    if (!von) return 3'b000;
    if (x >= 32 && x <= 35 && (i == 0 || (y >= m_pl[i] && y <= m_pl[i] + BAR_H - 1))) return 3'b001;
    if (x >= 600 && x <= 603 && y >= m_pr[i] && y <= m_pr[i] + BAR_H - 1) return 3'b010;
    if (m_st[i] != M_IDLE && m_st[i] != M_OVER &&
        x >= m_bx[i] && x <= m_bx[i] + 7 && y >= m_by[i] && y <= m_by[i] + 7) begin
      row = rom_row(y - m_by[i]);
      if (row[x - m_bx[i]]) return 3'b100;
    end
    return 3'b110;
  endfunction

  function automatic exp_t model_expect(int x, int y, bit von);
    exp_t e;
    e.rgb0 = model_pixel(0, x, y, von); e.rgb1 = model_pixel(1, x, y, von);
    e.sl0 = 4'(m_sl[0]); e.sr0 = 4'(m_sr[0]); e.sl1 = 4'(m_sl[1]); e.sr1 = 4'(m_sr[1]);
    e.go0 = (m_st[0] == M_OVER); e.go1 = (m_st[1] == M_OVER);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, want);
    end
  endtask

  // Scoreboard monitor: one expected entry per probed pixel, compared a cycle later.
  always @(posedge clk) pend <= probe_active;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rgb_1p", rgb0, e.rgb0);     check("rgb_2p", rgb1, e.rgb1);
        check("score_l_1p", sl0, e.sl0);   check("score_r_1p", sr0, e.sr0);
        check("score_l_2p", sl1, e.sl1);   check("score_r_2p", sr1, e.sr1);
        check("game_over_1p", go0, e.go0); check("game_over_2p", go1, e.go1);
      end
    end
  end

  task automatic tick_cycle(input bit rst);
    @(negedge clk);
    pix_x = 10'd0; pix_y = 10'(V + 1); video_on = 1'b0; start = 1'b0; reset = rst; probe_active = 1'b0;
    if (rst) model_reset();
    else for (int i = 0; i < 2; i++) model_tick(i);
  endtask

  task automatic probe(input int x, input int y, input bit von, input bit rst);
    exp_t e;
    x = ((x % 1024) + 1024) % 1024;
    y = ((y % V) + V) % V;
    @(negedge clk);
    pix_x = 10'(x); pix_y = 10'(y); video_on = von; start = 1'b0; reset = rst; probe_active = 1'b1;
    if (rst) begin
      model_reset();
      e = model_expect(x, y, von);
      e.rgb0 = 3'b000; e.rgb1 = 3'b000;
    end else begin
      e = model_expect(x, y, von);
    end
    exp_q.push_back(e);
  endtask

  task automatic start_cycle();
    @(negedge clk);
    pix_x = 10'd7; pix_y = 10'd7; video_on = 1'b1; start = 1'b1; reset = 1'b0; probe_active = 1'b0;
    model_start();
  endtask

  task automatic frame();
    tick_cycle(1'b0);
    for (int i = 0; i < 2; i++) begin
      probe(m_bx[i] + 3, m_by[i] + 3, 1'b1, 1'b0);
      probe(m_bx[i], m_by[i], 1'b1, 1'b0);
      probe(m_bx[i] + 4, m_by[i] + 7, 1'b1, 1'b0);
    end
    probe(601, m_pr[0] - 1, 1'b1, 1'b0);
    probe(601, m_pr[0], 1'b1, 1'b0);
    probe(602, m_pr[0] + BAR_H - 1, 1'b1, 1'b0);
    probe(603, m_pr[0] + BAR_H, 1'b1, 1'b0);
    probe(33, m_pl[1] - 1, 1'b1, 1'b0);
    probe(34, m_pl[1] + BAR_H - 1, 1'b1, 1'b0);
    probe(35, m_pl[1] + BAR_H, 1'b1, 1'b0);
    probe(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), $urandom_range(0, 7) != 0, 1'b0);
  endtask

  function automatic logic [1:0] rand_pad();
    case ($urandom_range(0, 4))
      0:       return 2'b00;
      1, 2:    return 2'b01;
      3:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [1:0] track(int ball_y, int top);
    if (ball_y < top + 20) return 2'b01;
    if (ball_y > top + 44) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    probe(33, 100, 1'b1, 1'b1);
    probe(601, 210, 1'b1, 1'b1);
    frame();
    frame();
    btn = 4'b1010;
    for (int f = 0; f < 100; f++) frame();
    btn = 4'b0101;
    for (int f = 0; f < 10; f++) frame();
    btn = 4'b1111;
    for (int f = 0; f < 5; f++) frame();
    btn = 4'b0000;
    start_cycle();
    for (int f = 0; f < 70; f++) frame();
    for (int f = 0; f < 1300; f++) begin
      if (f % 6 == 0) begin
        if ((f / 200) % 2 == 0) btn = {rand_pad(), rand_pad()};
        else btn = {track(m_by[1], m_pl[1]), track(m_by[0], m_pr[0])};
      end
      if (m_st[0] == M_OVER || m_st[1] == M_OVER) start_cycle();
      frame();
    end
    btn = 4'b0000;
    if (m_st[0] == M_IDLE || m_st[0] == M_OVER) start_cycle();
    for (int f = 0; f < 100 && m_st[0] != M_PLAY; f++) frame();
    frame();
    tick_cycle(1'b1);
    probe(m_bx[0] + 3, m_by[0] + 3, 1'b1, 1'b0);
    probe(600, m_pr[0], 1'b1, 1'b0);
    probe(33, 30, 1'b1, 1'b0);
    start_cycle();
    for (int f = 0; f < 3; f++) frame();
    @(negedge clk);
    probe_active = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pong_game_graph.md
# pong_game_graph

Parametrised pixel generator and game engine for the Pong display path. It sits between the VGA sync generator (pix_x/pix_y/video_on) and the RGB output pins, like the single-player animation block it supersedes. It adds:
- selectable one- or two-player mode with a second paddle;
- per-side score counters;
- a serve/point/game-over state machine;
- parametrised geometry and speeds.

## Interface
- H_ACTIVE, 640: visible columns.
- V_ACTIVE, 480: visible rows.
- TWO_PLAYER, 0: 0 = fixed left wall at x 32..35; 1 = left paddle at x 32..35.
- BAR_Y_SIZE, 72: paddle height in rows; paddle width is fixed at 4.
- BAR_V, 4: paddle step per frame.
- BALL_SIZE, 8: ball side; must be 8 (round-ball ROM is 8x8).
- BALL_V, 2: ball step per frame, each axis.
- SERVE_FRAMES, 60: frames the ball is held at centre before launch.
- SCORE_W, 4: score counter width.
- WIN_SCORE, 9: score that ends the game; must be < 2^SCORE_W.
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- video_on  in  1  high in the visible area.
- pix_x, pix_y  in  10 each  current pixel coordinate.
- btn  in  4  [0] right up, [1] right down, [2] left up, [3] left down. [3:2] are ignored when TWO_PLAYER = 0.
- start  in  1  level; starts a game from IDLE or OVER.
- graph_rgb  out  3  pixel colour, registered.
- score_l, score_r  out  SCORE_W  points won by the left and right sides.
- game_over  out  1  high in state OVER.

## Operation
- Frame tick: refr_tick = (pix_y == V_ACTIVE+1) && (pix_x == 0), one cycle per frame. All position, velocity, counter and FSM updates happen only on refr_tick, except reset and the IDLE/OVER start check.
- States:
  - IDLE: ball hidden, paddles movable; start=1 → SERVE, clears both scores.
  - SERVE: ball drawn at (H_ACTIVE/2-4, V_ACTIVE/2-4); frame counter counts SERVE_FRAMES ticks → PLAY.
  - PLAY: ball moves.
  - POINT: one tick; increments the scorer. If that score == WIN_SCORE → OVER, else → SERVE.
  - OVER: ball hidden; start=1 → SERVE with scores cleared.
- Serve direction:
  - dy = +BALL_V always.
  - dx is toward the side that lost the last point.
  - The first serve goes right (dx = +BALL_V).
- Paddles: each tick, "down" has priority over "up".
  - Move down by BAR_V if bottom + BAR_V <= V_ACTIVE-1.
  - Move up by BAR_V if top >= BAR_V.
  - Otherwise the paddle holds.
- Ball update in PLAY, evaluated in this order on the current position before the position add:
  - top ≤ BALL_V → dy = +BALL_V.
  - bottom ≥ V_ACTIVE-1-BALL_V → dy = -BALL_V.
  - Right edge in [BAR_X_L, BAR_X_R] (600..603) with y-overlap on the right paddle → dx = -BALL_V.
  - Left edge in [32,35]: in 1-player mode, always; in 2-player mode, only with y-overlap on the left paddle → dx = +BALL_V.
  - A y-bounce and an x-bounce in the same tick are both applied.
- Then pos += delta, in 10-bit two's complement.
- Miss, checked before bounces:
  - Right edge > BAR_X_R + BALL_V → left side scores → POINT.
  - In 2-player mode, left edge < 32 or wrapped (≥ H_ACTIVE) → right side scores → POINT.
  - In 1-player mode, only the right miss exists. score_l counts misses and score_r counts paddle hits (saturating at 2^SCORE_W-1).
- Drawing priority, highest first:
  - video_on=0 → 000.
  - wall/left paddle → 001.
  - right paddle → 010.
  - round ball (8x8 ROM masked by square, rows 3C,7E,FF,FF,FF,FF,7E,3C) → 100, only when not in IDLE/OVER.
  - background → 110.

## Timing
- graph_rgb is registered: one clk cycle latency from pix_x/pix_y/video_on. The sync generator delays hsync/vsync by one cycle to match.
- Reset state (next edge with reset=1):
  - FSM = IDLE, paddles top = (V_ACTIVE-BAR_Y_SIZE)/2, ball at centre.
  - dx = +BALL_V, dy = +BALL_V.
  - Scores 0, serve counter 0, graph_rgb = 000, game_over = 0.
- Reset mid-game overrides everything, including a coincident refr_tick.
- start is sampled every cycle in IDLE/OVER. A transition taken mid-frame makes SERVE begin counting at the next refr_tick.
- Score updates are visible on score_l/score_r the cycle after the POINT tick. game_over rises the cycle after the tick that enters OVER.
- Paddle and ball moves are at most one step per frame; no sub-frame motion.

## Test plan
- Reset, then run 2 frames with no buttons → graph_rgb = 000 one cycle after reset; ball hidden; right paddle rows 204..275 at x=600 read 010; left wall reads 001.
- start=1 in IDLE → exactly 60 frames at centre (x 316..323), then 61st tick moves the ball to (318,238).
- btn[1] held 100 frames → right paddle bottom stops at ≤ 479 and never exceeds it. Then btn[0]+btn[1] together → paddle moves down (priority).
- 1-player mode: force ball toward the wall at dy=+2 → dx flips to +2 at left edge 34 and dy flips at the bottom without losing the x bounce.
- 2-player mode: hold the left paddle at top while the ball goes left → score_r increments to 1, state SERVE, next serve dx = -2.
- WIN_SCORE=2: two right misses → score_l=2, game_over=1, ball hidden. start → scores 0, game_over=0. Assert reset during PLAY → IDLE next cycle.
